// File: rtl/pulse_period_monitor.sv
// Measures clk cycles between rising edges of pulse_in, declares lock on a stable period and flags stream loss.
// Optional PULSE_SYNC_EN: inserts a two-flop synchronizer ahead of edge detection (adds 2 cycles of latency).
module pulse_period_monitor #(
    parameter int CNT_W      = 8,
    parameter int EXPECTED   = 6,
    parameter int TOLERANCE  = 0,
    parameter int LOCK_COUNT = 3,
    parameter int TIMEOUT    = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pulse_in,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             timeout,
    output logic [3:0]       edge_count
);

    localparam logic [CNT_W-1:0] TO_V   = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] EXP_V  = CNT_W'(EXPECTED);
    localparam logic [CNT_W-1:0] TOL_V  = CNT_W'(TOLERANCE);
    localparam logic [3:0]       LOCK_V = 4'(LOCK_COUNT);

    typedef enum logic [1:0] {S_WAIT, S_MEAS, S_LOCK, S_LOST} state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [3:0]       match_reg, match_next;
    logic [CNT_W-1:0] period_reg, period_next;
    logic             valid_reg, valid_next;
    logic             locked_reg, timeout_reg;
    logic [3:0]       edge_count_reg;
    logic             prev_reg;
    logic             pulse_s;
    logic             edge_det;
    logic [CNT_W-1:0] diff;
    logic             is_match;
    logic             at_limit;

`ifdef PULSE_SYNC_EN
    logic [1:0] sync_reg;

    // Both stages reset high so a level held across reset is not seen as an edge.
    always_ff @(posedge clk) begin
        if (!rst) sync_reg <= 2'b11;
        else      sync_reg <= {sync_reg[0], pulse_in};
    end
    assign pulse_s = sync_reg[1];
`else
    assign pulse_s = pulse_in;
`endif

    assign edge_det = pulse_s & ~prev_reg;
    assign at_limit = (cnt_reg == TO_V);
    assign diff     = (cnt_reg >= EXP_V) ? (cnt_reg - EXP_V) : (EXP_V - cnt_reg);
    assign is_match = (diff <= TOL_V);

    always_comb begin
        cnt_next = cnt_reg;
        if (edge_det)      cnt_next = {{(CNT_W-1){1'b0}}, 1'b1};
        else if (!at_limit) cnt_next = cnt_reg + 1'b1;
    end

    always_comb begin
        state_next  = state_reg;
        match_next  = match_reg;
        period_next = period_reg;
        valid_next  = 1'b0;
        case (state_reg)
            S_WAIT: begin
                if (edge_det) state_next = S_MEAS;
            end
            S_MEAS: begin
                if (edge_det) begin
                    period_next = cnt_reg;
                    valid_next  = 1'b1;
                    if (is_match) begin
                        if ((match_reg + 4'd1) >= LOCK_V) begin
                            match_next = LOCK_V;
                            state_next = S_LOCK;
                        end else begin
                            match_next = match_reg + 4'd1;
                        end
                    end else begin
                        match_next = 4'd0;
                    end
                end else if (at_limit) begin
                    state_next = S_LOST;
                end
            end
            S_LOCK: begin
                if (edge_det) begin
                    period_next = cnt_reg;
                    valid_next  = 1'b1;
                    if (!is_match) begin
                        match_next = 4'd0;
                        state_next = S_MEAS;
                    end
                end else if (at_limit) begin
                    state_next = S_LOST;
                end
            end
            S_LOST: begin
                // The gap that ended here is not a period, so nothing is reported.
                if (edge_det) begin
                    match_next = 4'd0;
                    state_next = S_MEAS;
                end
            end
            default: state_next = S_WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg      <= S_WAIT;
            cnt_reg        <= '0;
            match_reg      <= 4'd0;
            period_reg     <= '0;
            valid_reg      <= 1'b0;
            locked_reg     <= 1'b0;
            timeout_reg    <= 1'b0;
            edge_count_reg <= 4'd0;
            prev_reg       <= 1'b1;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            match_reg      <= match_next;
            period_reg     <= period_next;
            valid_reg      <= valid_next;
            locked_reg     <= (state_next == S_LOCK);
            timeout_reg    <= (state_next == S_LOST);
            edge_count_reg <= edge_count_reg + {3'b000, edge_det};
            prev_reg       <= pulse_s;
        end
    end

    assign period       = period_reg;
    assign period_valid = valid_reg;
    assign locked       = locked_reg;
    assign timeout      = timeout_reg;
    assign edge_count   = edge_count_reg;

endmodule

// File: tb/tb_pulse_period_monitor.sv
// Scoreboard bench for pulse_period_monitor: directed pulse trains push expected reports, a forked monitor checks them.
module tb_pulse_period_monitor;

`ifdef PULSE_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       pulse_in = 1'b0;
    logic [7:0] period;
    logic       period_valid;
    logic       locked;
    logic       timeout;
    logic [3:0] edge_count;

    typedef struct {
        int period;
        int locked;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    pulse_period_monitor dut (
        .clk          (clk),
        .rst          (rst),
        .pulse_in     (pulse_in),
        .period       (period),
        .period_valid (period_valid),
        .locked       (locked),
        .timeout      (timeout),
        .edge_count   (edge_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic push(input int p, input int l);
        exp_t e;
        e.period = p;
        e.locked = l;
        exp_q.push_back(e);
    endtask

    // One-cycle high pulse; the next call's edge lands 'gap' cycles after this one.
    task automatic pulse(input int gap, input bit do_push, input int p, input int l);
        if (do_push) push(p, l);
        pulse_in = 1'b1;
        @(posedge clk); #1;
        pulse_in = 1'b0;
        repeat (gap - 1) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (rst && period_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_valid", 1, 0);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("sb_period", int'(period), e.period);
                        chk("sb_locked", int'(locked), e.locked);
                    end
                end
            end
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_period", int'(period), 0);
        chk("rst_valid", int'(period_valid), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_timeout", int'(timeout), 0);
        chk("rst_edge_count", int'(edge_count), 0);
        rst = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
        end

        // Nominal lock, then one 9-cycle glitch and relock
        pulse(6, 0, 0, 0);
        pulse(6, 1, 6, 0);
        pulse(6, 1, 6, 0);
        pulse(6, 1, 6, 1);
        chk("nominal_locked", int'(locked), 1);
        pulse(9, 1, 6, 1);
        pulse(6, 1, 9, 0);
        pulse(6, 1, 6, 0);
        pulse(6, 1, 6, 0);
        pulse(6, 1, 6, 1);
        chk("relock_locked", int'(locked), 1);

        // Stream loss: last edge then silence
        pulse(1, 1, 6, 1);
        repeat (254 + LAT) begin
            @(posedge clk); #1;
        end
        chk("loss_timeout_early", int'(timeout), 0);
        @(posedge clk); #1;
        chk("loss_timeout", int'(timeout), 1);
        chk("loss_locked", int'(locked), 0);
        pulse(6, 0, 0, 0);
        chk("loss_cleared", int'(timeout), 0);
        pulse(6, 1, 6, 0);
        chk("edge_count_12", int'(edge_count), 12);

        // Wide pulse: one edge only
        push(6, 0);
        pulse_in = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
        end
        chk("wide_edge_count", int'(edge_count), 13);
        pulse_in = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        chk("wide_edge_count_after", int'(edge_count), 13);
        pulse(6, 1, 25, 0);
        pulse(6, 1, 6, 0);
        pulse(6, 1, 6, 0);
        pulse(6, 1, 6, 1);

        // Reset mid-lock while pulse_in is high
        pulse_in = 1'b1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("midrst_period", int'(period), 0);
        chk("midrst_valid", int'(period_valid), 0);
        chk("midrst_locked", int'(locked), 0);
        chk("midrst_timeout", int'(timeout), 0);
        chk("midrst_edge_count", int'(edge_count), 0);
        rst = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
        end
        chk("release_edge_count", int'(edge_count), 0);
        pulse_in = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end

        // Fresh start from WAIT, then an edge exactly at the TIMEOUT boundary
        pulse(6, 0, 0, 0);
        pulse(255, 1, 6, 0);
        pulse(1, 1, 255, 0);
        repeat (LAT) begin
            @(posedge clk); #1;
        end
        chk("boundary_timeout", int'(timeout), 0);
        chk("boundary_edge_count", int'(edge_count), 3);

        repeat (5) begin
            @(posedge clk); #1;
        end
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
